// File: rtl/msg_arb_pkg.sv
// Shared state encoding and round-robin search helper for msg_stream_arbiter.
package msg_arb_pkg;

    localparam int MAX_SRC   = 16;
    localparam int MAX_IDX_W = 4;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_BUSY,
        ARB_FLUSH
    } arb_state_t;

    // Requests above the real source count are zero-padded. That keeps a mod-MAX_SRC
    // walk in the same order as a mod-NUM_SRC walk, so this one helper fits every legal width.
    function automatic logic [MAX_IDX_W-1:0] rr_pick(
        input logic [MAX_SRC-1:0]   req,
        input logic [MAX_IDX_W-1:0] last
    );
        logic [MAX_IDX_W-1:0] idx;
        rr_pick = last;
        for (int k = MAX_SRC; k >= 1; k--) begin
            idx = last + MAX_IDX_W'(k);
            if (req[idx]) begin
                rr_pick = idx;
            end
        end
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin search: the first requester after i_last, wrapping modulo NUM_SRC.
module rr_priority_picker
    import msg_arb_pkg::*;
#(
    parameter int NUM_SRC = 4
) (
    input  logic [NUM_SRC-1:0]         i_req,
    input  logic [$clog2(NUM_SRC)-1:0] i_last,
    output logic                       o_found,
    output logic [$clog2(NUM_SRC)-1:0] o_index
);

    localparam int IDX_W = $clog2(NUM_SRC);

    assign o_found = |i_req;
    assign o_index = IDX_W'(rr_pick(MAX_SRC'(i_req), MAX_IDX_W'(i_last)));

endmodule

// File: rtl/msg_stream_arbiter.sv
// Packet-atomic round-robin arbiter sharing one msg_parser AXI-Stream port between NUM_SRC sources.
// Define MSG_ARB_WATCHDOG_EN to add the stall watchdog, the FLUSH state and the watchdog_err output.
module msg_stream_arbiter
    import msg_arb_pkg::*;
#(
    parameter int NUM_SRC        = 4,
    parameter int DATA_BYTES     = 8,
    parameter int TKEEP_WIDTH    = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_SRC-1:0]              s_tvalid,
    output logic [NUM_SRC-1:0]              s_tready,
    input  logic [NUM_SRC-1:0]              s_tlast,
    input  logic [NUM_SRC-1:0]              s_tuser,
    input  logic [NUM_SRC*8*DATA_BYTES-1:0] s_tdata,
    input  logic [NUM_SRC*TKEEP_WIDTH-1:0]  s_tkeep,
    output logic                            m_tvalid,
    input  logic                            m_tready,
    output logic                            m_tlast,
    output logic                            m_tuser,
    output logic [8*DATA_BYTES-1:0]         m_tdata,
    output logic [TKEEP_WIDTH-1:0]          m_tkeep,
    output logic [$clog2(NUM_SRC)-1:0]      grant_id,
    output logic                            busy
`ifdef MSG_ARB_WATCHDOG_EN
    ,
    output logic                            watchdog_err
`endif
);

    localparam int DW = 8 * DATA_BYTES;
    localparam int GW = $clog2(NUM_SRC);

    arb_state_t           r_state;
    logic [GW-1:0]        r_grant;
    logic [GW-1:0]        r_last_grant;

    logic                 w_found;
    logic [GW-1:0]        w_pick;
    logic                 w_src_valid;
    logic                 w_src_last;
    logic                 w_src_user;
    logic [DW-1:0]        w_src_data;
    logic [TKEEP_WIDTH-1:0] w_src_keep;
    logic                 w_synth;
    logic                 w_hs;

    rr_priority_picker #(
        .NUM_SRC (NUM_SRC)
    ) u_picker (
        .i_req   (s_tvalid),
        .i_last  (r_last_grant),
        .o_found (w_found),
        .o_index (w_pick)
    );

    assign w_src_valid = s_tvalid[r_grant];
    assign w_src_last  = s_tlast[r_grant];
    assign w_src_user  = s_tuser[r_grant];
    assign w_src_data  = s_tdata[int'(r_grant)*DW +: DW];
    assign w_src_keep  = s_tkeep[int'(r_grant)*TKEEP_WIDTH +: TKEEP_WIDTH];

`ifdef MSG_ARB_WATCHDOG_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] r_stall_cnt;
    logic          r_wd_fire;
    logic          r_wd_err;

    // r_wd_fire holds the synthetic error beat on m_* until msg_parser accepts it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
            r_wd_fire   <= 1'b0;
            r_wd_err    <= 1'b0;
        end else if (r_state == ARB_BUSY && !r_wd_fire) begin
            if (w_src_valid) begin
                r_stall_cnt <= '0;
            end else if (r_stall_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                r_stall_cnt <= '0;
                r_wd_fire   <= 1'b1;
                r_wd_err    <= 1'b1;
            end else begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end else if (r_wd_fire) begin
            if (m_tready) begin
                r_wd_fire <= 1'b0;
            end
        end else begin
            r_stall_cnt <= '0;
        end
    end

    assign w_synth      = r_wd_fire;
    assign watchdog_err = r_wd_err;
`else
    // The stall limit has no meaning without the watchdog.
    localparam int unused_timeout = TIMEOUT_CYCLES;
    assign w_synth = 1'b0;
`endif

    always_comb begin
        // NOTE: every output gets a default first, so no branch below can infer a latch.
        m_tvalid = 1'b0;
        m_tlast  = 1'b0;
        m_tuser  = 1'b0;
        m_tdata  = '0;
        m_tkeep  = '0;
        s_tready = '0;
        case (r_state)
            ARB_BUSY: begin
                if (w_synth) begin
                    m_tvalid = 1'b1;
                    m_tlast  = 1'b1;
                    m_tuser  = 1'b1;
                end else begin
                    m_tvalid          = w_src_valid;
                    m_tlast           = w_src_last;
                    m_tuser           = w_src_user;
                    m_tdata           = w_src_data;
                    m_tkeep           = w_src_keep;
                    s_tready[r_grant] = m_tready;
                end
            end
`ifdef MSG_ARB_WATCHDOG_EN
            ARB_FLUSH: s_tready[r_grant] = 1'b1;
`endif
            default: ;
        endcase
    end

    assign w_hs = m_tvalid & m_tready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the outputs decode from r_state, so this reset blanks them without a clock edge.
            r_state      <= ARB_IDLE;
            r_grant      <= '0;
            r_last_grant <= GW'(NUM_SRC - 1);
        end else begin
            // NOTE: sequential state updates use non-blocking assignments only.
            case (r_state)
                ARB_IDLE: begin
                    if (w_found) begin
                        r_grant <= w_pick;
                        r_state <= ARB_BUSY;
                    end
                end
                ARB_BUSY: begin
                    if (w_hs && m_tlast) begin
                        if (w_synth) begin
                            r_state <= ARB_FLUSH;
                        end else begin
                            r_last_grant <= r_grant;
                            r_state      <= ARB_IDLE;
                        end
                    end
                end
                ARB_FLUSH: begin
                    if (w_src_valid && w_src_last) begin
                        r_last_grant <= r_grant;
                        r_state      <= ARB_IDLE;
                    end
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

    assign grant_id = r_grant;
    assign busy     = (r_state != ARB_IDLE);

endmodule

// File: tb/tb_msg_stream_arbiter.sv
// Directed scoreboard bench for msg_stream_arbiter; also exercises the watchdog when MSG_ARB_WATCHDOG_EN is defined.
`timescale 1ns/1ps
module tb_msg_stream_arbiter;

    localparam int NUM_SRC        = 4;
    localparam int DATA_BYTES     = 8;
    localparam int TKEEP_WIDTH    = 8;
    localparam int TIMEOUT_CYCLES = 8;
    localparam int DW             = 8 * DATA_BYTES;
`ifdef MSG_ARB_WATCHDOG_EN
    localparam int STALL3 = 6;
`else
    localparam int STALL3 = 10;
`endif

    typedef struct {
        logic [DW-1:0]          data;
        logic [TKEEP_WIDTH-1:0] keep;
        logic                   last;
        logic                   user;
        int                     src;
    } beat_t;

    logic                            clk = 1'b0;
    logic                            rst;
    logic [NUM_SRC-1:0]              s_tvalid;
    logic [NUM_SRC-1:0]              s_tready;
    logic [NUM_SRC-1:0]              s_tlast;
    logic [NUM_SRC-1:0]              s_tuser;
    logic [NUM_SRC*DW-1:0]           s_tdata;
    logic [NUM_SRC*TKEEP_WIDTH-1:0]  s_tkeep;
    logic                            m_tvalid;
    logic                            m_tready;
    logic                            m_tlast;
    logic                            m_tuser;
    logic [DW-1:0]                   m_tdata;
    logic [TKEEP_WIDTH-1:0]          m_tkeep;
    logic [$clog2(NUM_SRC)-1:0]      grant_id;
    logic                            busy;
`ifdef MSG_ARB_WATCHDOG_EN
    logic                            watchdog_err;
`endif

    msg_stream_arbiter #(
        .NUM_SRC        (NUM_SRC),
        .DATA_BYTES     (DATA_BYTES),
        .TKEEP_WIDTH    (TKEEP_WIDTH),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_tvalid     (s_tvalid),
        .s_tready     (s_tready),
        .s_tlast      (s_tlast),
        .s_tuser      (s_tuser),
        .s_tdata      (s_tdata),
        .s_tkeep      (s_tkeep),
        .m_tvalid     (m_tvalid),
        .m_tready     (m_tready),
        .m_tlast      (m_tlast),
        .m_tuser      (m_tuser),
        .m_tdata      (m_tdata),
        .m_tkeep      (m_tkeep),
        .grant_id     (grant_id),
`ifdef MSG_ARB_WATCHDOG_EN
        .watchdog_err (watchdog_err),
`endif
        .busy         (busy)
    );

    always #5 clk = ~clk;

    beat_t              src_q [NUM_SRC][$];
    beat_t              exp_q [$];
    logic [NUM_SRC-1:0] src_hold;
    int                 n_vec;
    int                 n_err;
    int                 cyc;
    int                 last_beat_cyc;
    logic               prev_tlast;
    bit                 chk_gap;
    bit                 chk_contig;
    bit                 chk_ready;
    bit                 tog;
    int                 t0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_beat(input int src, input logic [DW-1:0] data, input logic [TKEEP_WIDTH-1:0] keep,
                             input logic last, input logic user, input bit to_exp);
        beat_t b;
        b.data = data;
        b.keep = keep;
        b.last = last;
        b.user = user;
        b.src  = src;
        src_q[src].push_back(b);
        if (to_exp) exp_q.push_back(b);
    endtask

    task automatic send(input int src, input int nbeats, input int tag);
        for (int k = 0; k < nbeats; k++) begin
            push_beat(src, {16'(src), 16'(tag), 32'(k) ^ 32'h5A5A_0000}, 8'hFF,
                      (k == nbeats - 1), (k == nbeats - 1) && (src % 2 == 1), 1'b1);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NUM_SRC; i++) begin
            if (src_q[i].size() != 0 && !src_hold[i]) begin
                s_tvalid[i]                             = 1'b1;
                s_tlast[i]                              = src_q[i][0].last;
                s_tuser[i]                              = src_q[i][0].user;
                s_tdata[i*DW +: DW]                     = src_q[i][0].data;
                s_tkeep[i*TKEEP_WIDTH +: TKEEP_WIDTH]   = src_q[i][0].keep;
            end else begin
                s_tvalid[i]                             = 1'b0;
                s_tlast[i]                              = 1'b0;
                s_tuser[i]                              = 1'b0;
                s_tdata[i*DW +: DW]                     = '0;
                s_tkeep[i*TKEEP_WIDTH +: TKEEP_WIDTH]   = '0;
            end
        end
    endtask

    task automatic monitor();
        beat_t e;
        if (chk_ready) check("s_tready_mirror", 64'(s_tready), m_tready ? 64'h4 : 64'h0);
        if (m_tvalid && m_tready) begin
            check("beat_expected", 64'(exp_q.size() > 0), 64'h1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("m_tdata", m_tdata, e.data);
                check("m_tkeep", 64'(m_tkeep), 64'(e.keep));
                check("m_tlast", 64'(m_tlast), 64'(e.last));
                check("m_tuser", 64'(m_tuser), 64'(e.user));
                check("grant_id", 64'(grant_id), 64'(e.src));
                if (last_beat_cyc >= 0) begin
                    if (prev_tlast && chk_gap) check("pkt_gap", 64'(cyc - last_beat_cyc), 64'd2);
                    else if (!prev_tlast && chk_contig) check("beat_contig", 64'(cyc - last_beat_cyc), 64'd1);
                end
                last_beat_cyc = cyc;
                prev_tlast    = m_tlast;
            end
        end
    endtask

    task automatic tick();
        logic [NUM_SRC-1:0] hs;
        @(negedge clk);
        cyc++;
        monitor();
        hs = s_tvalid & s_tready;
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (hs[i]) void'(src_q[i].pop_front());
        end
        if (tog) m_tready = ~m_tready;
        drive();
    endtask

    function automatic bit src_pending();
        for (int i = 0; i < NUM_SRC; i++) begin
            if (src_q[i].size() != 0) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || src_pending()) && n < 200) begin
            tick();
            n++;
        end
        check({tag, "_drain"}, 64'(n < 200), 64'h1);
    endtask

    task automatic begin_test(input bit gap, input bit contig);
        last_beat_cyc = -1;
        prev_tlast    = 1'b0;
        chk_gap       = gap;
        chk_contig    = contig;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not reach its summary");
        $fatal(1, "global timeout");
    end

    initial begin
        n_vec     = 0;
        n_err     = 0;
        cyc       = 0;
        rst       = 1'b0;
        m_tready  = 1'b0;
        src_hold  = '0;
        tog       = 1'b0;
        chk_ready = 1'b0;
        begin_test(1'b0, 1'b0);
        drive();
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_grant", 64'(grant_id), 64'h0);
        check("rst_m_tvalid", 64'(m_tvalid), 64'h0);
        check("rst_s_tready", 64'(s_tready), 64'h0);
`ifdef MSG_ARB_WATCHDOG_EN
        check("rst_wd_err", 64'(watchdog_err), 64'h0);
`endif
        rst      = 1'b1;
        m_tready = 1'b1;
        tick();
        check("idle_busy", 64'(busy), 64'h0);

        // Four simultaneous 3-beat packets: grants 0,1,2,3, contiguous, one idle cycle between.
        begin_test(1'b1, 1'b1);
        for (int s = 0; s < NUM_SRC; s++) send(s, 3, 1);
        drive();
        drain("rr4");

        // Source 2 alone with m_tready toggling; s_tready must mirror it on source 2 only.
        begin_test(1'b0, 1'b0);
        send(2, 4, 2);
        drive();
        tick();
        chk_ready = 1'b1;
        tog       = 1'b1;
        drain("toggle");
        chk_ready = 1'b0;
        tog       = 1'b0;
        m_tready  = 1'b1;

        // Source 1 stalls mid-packet while source 0 requests: grant must stay on 1.
        begin_test(1'b1, 1'b0);
        send(1, 4, 3);
        drive();
        repeat (3) tick();
        src_hold[1] = 1'b1;
        send(0, 2, 3);
        drive();
        repeat (STALL3) begin
            tick();
            check("stall_busy", 64'(busy), 64'h1);
            check("stall_grant", 64'(grant_id), 64'h1);
        end
        src_hold[1] = 1'b0;
        drive();
        drain("stall");

        // Single-beat packet with tuser and partial tkeep passes through unchanged.
        begin_test(1'b0, 1'b0);
        push_beat(3, 64'h0000_0000_DEAD_BEEF, 8'h0F, 1'b1, 1'b1, 1'b1);
        drive();
        t0 = cyc;
        drain("single");
        check("single_latency", 64'(last_beat_cyc - t0), 64'd2);

        // Move last_grant to 1, then reset in the middle of a source 0 packet.
        begin_test(1'b0, 1'b0);
        send(1, 1, 4);
        drive();
        drain("pre_rst");
        send(0, 4, 5);
        drive();
        repeat (3) tick();
        check("pre_rst_valid", 64'(m_tvalid), 64'h1);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_m_tvalid", 64'(m_tvalid), 64'h0);
        check("async_rst_busy", 64'(busy), 64'h0);
        check("async_rst_s_tready", 64'(s_tready), 64'h0);
        check("async_rst_grant", 64'(grant_id), 64'h0);
        check("async_rst_m_tdata", m_tdata, 64'h0);
        for (int i = 0; i < NUM_SRC; i++) src_q[i].delete();
        exp_q.delete();
        drive();
        repeat (2) tick();
        rst = 1'b1;
        begin_test(1'b1, 1'b1);
        send(0, 2, 6);
        send(2, 2, 6);
        drive();
        drain("post_rst");

`ifdef MSG_ARB_WATCHDOG_EN
        // Source 2 stalls past the limit: one synthetic error beat, then the tail is flushed.
        begin_test(1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            push_beat(2, {32'hC0DE_0000, 32'(k)}, 8'hFF, (k == 3), 1'b0, (k < 2));
        end
        push_beat(2, '0, '0, 1'b1, 1'b1, 1'b1);
        void'(src_q[2].pop_back());
        drive();
        repeat (3) tick();
        src_hold[2] = 1'b1;
        drive();
        repeat (10) tick();
        check("wd_err", 64'(watchdog_err), 64'h1);
        check("wd_flush_busy", 64'(busy), 64'h1);
        src_hold[2] = 1'b0;
        drive();
        drain("wd_flush");
        tick();
        check("wd_idle", 64'(busy), 64'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
